// File: rtl/rr_sel_encoder.sv
// Round-robin request encoder: picks one active requester per capture, starting
// from a rotating pointer, and presents its index and data word over valid/ready.
module rr_sel_encoder #(
  parameter int NREQ = 16,
  parameter int CW   = 4,
  parameter int DW   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_code,
  output logic [DW-1:0]        out_data,
  output logic                 idle
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_ptr;
  logic [CW-1:0]     r_code;
  logic [DW-1:0]     r_data;
  logic [NREQ-1:0]   r_gnt;

  logic              w_cap_ok;
  logic              w_capture;
  logic [CW-1:0]     w_win;
  logic [CW-1:0]     w_ptr_nxt;
  logic [DW-1:0]     w_win_data;
  logic [NREQ-1:0]   w_win_oh;

  // First set request at or after the pointer, wrapping modulo NREQ.
  // The sum is one bit wider than the code so ptr+k cannot overflow before the wrap.
  function automatic logic [CW-1:0] f_rr_pick(input logic [NREQ-1:0] f_req,
                                              input logic [CW-1:0]   f_ptr);
    logic [CW-1:0] win;
    logic          found;
    logic [CW:0]   idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, f_ptr} + (CW+1)'(k);
      if (idx >= (CW+1)'(NREQ)) begin
        idx = idx - (CW+1)'(NREQ);
      end
      if (!found && f_req[idx[CW-1:0]]) begin
        win   = idx[CW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // ---- arbitration (combinational) ----
  assign w_cap_ok  = en & (|req);
  assign w_win     = f_rr_pick(req, r_ptr);
  assign w_ptr_nxt = (w_win == CW'(NREQ-1)) ? '0 : (w_win + CW'(1));

  always_comb begin
    w_win_data = '0;
    w_win_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == CW'(i)) begin
        w_win_data  = req_data[i*DW +: DW];
        w_win_oh[i] = 1'b1;
      end
    end
  end

  // A new word may be captured when nothing is pending or the pending word
  // leaves this cycle, so back-to-back transfers run without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cap_ok) begin
          w_capture   = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (out_ready) begin
          if (w_cap_ok) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_code  <= '0;
      r_data  <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_capture ? w_win_oh : '0;
      if (w_capture) begin
        r_ptr  <= w_ptr_nxt;
        r_code <= w_win;
        r_data <= w_win_data;
      end
    end
  end

  assign gnt       = r_gnt;
  assign out_valid = (r_state == S_BUSY);
  assign out_code  = r_code;
  assign out_data  = r_data;
  assign idle      = (r_state == S_IDLE);

endmodule
